// File: rtl/i2c_slave_rx_if.sv
// Bus bundle for i2c_slave_rx.
// Groups the sampled I2C pins, the open-drain SDA pull-down, and the
// AXI-Stream-style byte output with its status flags.
//   slave  modport: the responder (drives sda_oe and the stream outputs)
//   master modport: the pin/stream environment (drives the pins and m_tready)
interface i2c_slave_rx_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  scl_i;
    logic                  sda_i;
    logic                  sda_oe;
    logic [DATA_WIDTH-1:0] m_tdata;
    logic                  m_tvalid;
    logic                  m_tready;
    logic                  m_rw;
    logic                  busy;
    logic                  overrun;

    modport slave (
        input  scl_i, sda_i, m_tready,
        output sda_oe, m_tdata, m_tvalid, m_rw, busy, overrun
    );

    modport master (
        output scl_i, sda_i, m_tready,
        input  sda_oe, m_tdata, m_tvalid, m_rw, busy, overrun
    );
endinterface

// File: rtl/i2c_slave_rx.sv
// Receive-only I2C responder.
// Oversamples SCL/SDA with clk, detects START/STOP, matches the address,
// ACKs the address and every accepted data byte, and presents bytes on a
// valid/ready stream. A byte arriving while the previous one is still held
// is NACKed and reported with a one-cycle overrun pulse.
// Ports:
//   clk  - system clock (>= 8x SCL)
//   arst - asynchronous active-high reset
//   bus  - i2c_slave_rx_if.slave: scl_i/sda_i pins, sda_oe pull-down,
//          m_tdata/m_tvalid/m_tready stream, m_rw, busy, overrun
module i2c_slave_rx #(
    parameter int unsigned           ADDR_WIDTH = 7,
    parameter int unsigned           DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] SLAVE_ADDR = 7'h50
) (
    input logic           clk,
    input logic           arst,
    i2c_slave_rx_if.slave bus
);
    localparam int unsigned SW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int unsigned CW = $clog2(SW + 1);

    typedef enum logic [2:0] {
        StIdle, StAddr, StRw, StAckAddr, StData, StAckData, StIgnore
    } state_e;

    state_e state_q, state_d;

    // Two-flop synchronizers plus one delayed copy for edge detection.
    logic scl_meta_q, scl_s_q, scl_d_q;
    logic sda_meta_q, sda_s_q, sda_d_q;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [SW-1:0]         sh_q, sh_d;
    logic                  ack_ph_q, ack_ph_d;     // 1 while our ACK slot is being driven
    logic                  ack_pend_q, ack_pend_d; // ACK/NACK decision for the last byte
    logic                  sda_oe_q, sda_oe_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  rw_q, rw_d;
    logic                  overrun_q, overrun_d;
    logic                  busy;

    logic scl_rise, scl_fall, start_det, stop_det, addr_match, accept;
    logic [DATA_WIDTH-1:0] byte_in;

    assign scl_rise   = scl_s_q & ~scl_d_q;
    assign scl_fall   = ~scl_s_q & scl_d_q;
    assign start_det  = scl_s_q & scl_d_q & ~sda_s_q & sda_d_q;
    assign stop_det   = scl_s_q & scl_d_q & sda_s_q & ~sda_d_q;
    assign addr_match = (sh_q[ADDR_WIDTH-1:0] == SLAVE_ADDR);
    assign accept     = tvalid_q & bus.m_tready;
    assign byte_in    = {sh_q[DATA_WIDTH-2:0], sda_s_q};

    // Synchronizers idle high, matching a released bus.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            scl_meta_q <= 1'b1;
            scl_s_q    <= 1'b1;
            scl_d_q    <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_s_q    <= 1'b1;
            sda_d_q    <= 1'b1;
        end else begin
            scl_meta_q <= bus.scl_i;
            scl_s_q    <= scl_meta_q;
            scl_d_q    <= scl_s_q;
            sda_meta_q <= bus.sda_i;
            sda_s_q    <= sda_meta_q;
            sda_d_q    <= sda_s_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state. START/STOP override every state.
    always_comb begin
        state_d = state_q;
        if (start_det) begin
            state_d = StAddr;
        end else if (stop_det) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StIgnore: state_d = state_q;
                StAddr:    if (scl_rise && cnt_q == '0) state_d = StRw;
                StRw:      if (scl_rise) state_d = addr_match ? StAckAddr : StIgnore;
                StAckAddr: if (scl_fall && ack_ph_q) state_d = StData;
                StData:    if (scl_rise && cnt_q == '0) state_d = StAckData;
                StAckData: if (scl_fall && ack_ph_q) state_d = StData;
                default:   state_d = StIdle;
            endcase
        end
    end

    // Outputs and datapath next values. sda_oe only moves on a detected
    // SCL fall (or START/STOP/reset), so it never changes while SCL is high.
    always_comb begin
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        ack_ph_d   = ack_ph_q;
        ack_pend_d = ack_pend_q;
        sda_oe_d   = sda_oe_q;
        tdata_d    = tdata_q;
        tvalid_d   = tvalid_q & ~accept;
        rw_d       = rw_q;
        overrun_d  = 1'b0;
        busy       = (state_q == StAckAddr) || (state_q == StData) || (state_q == StAckData);

        if (start_det) begin
            cnt_d    = CW'(ADDR_WIDTH - 1);
            ack_ph_d = 1'b0;
            sda_oe_d = 1'b0;
        end else if (stop_det) begin
            ack_ph_d = 1'b0;
            sda_oe_d = 1'b0;
        end else begin
            unique case (state_q)
                StAddr, StData: begin
                    if (scl_rise) begin
                        sh_d  = {sh_q[SW-2:0], sda_s_q};
                        cnt_d = cnt_q - CW'(1);
                        if (state_q == StData && cnt_q == '0) begin
                            ack_ph_d = 1'b0;
                            // A same-cycle handshake frees the holding register.
                            if (!tvalid_q || accept) begin
                                tdata_d    = byte_in;
                                tvalid_d   = 1'b1;
                                ack_pend_d = 1'b1;
                            end else begin
                                overrun_d  = 1'b1;
                                ack_pend_d = 1'b0;
                            end
                        end
                    end
                end
                StRw: begin
                    if (scl_rise) begin
                        rw_d     = sda_s_q;
                        ack_ph_d = 1'b0;
                    end
                end
                StAckAddr, StAckData: begin
                    if (scl_fall) begin
                        if (!ack_ph_q) begin
                            sda_oe_d = (state_q == StAckAddr) ? 1'b1 : ack_pend_q;
                            ack_ph_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            ack_ph_d = 1'b0;
                            cnt_d    = CW'(DATA_WIDTH - 1);
                        end
                    end
                end
                default: sda_oe_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt_q      <= '0;
            sh_q       <= '0;
            ack_ph_q   <= 1'b0;
            ack_pend_q <= 1'b0;
            sda_oe_q   <= 1'b0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            rw_q       <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            ack_ph_q   <= ack_ph_d;
            ack_pend_q <= ack_pend_d;
            sda_oe_q   <= sda_oe_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            rw_q       <= rw_d;
            overrun_q  <= overrun_d;
        end
    end

    assign bus.sda_oe   = sda_oe_q;
    assign bus.m_tdata  = tdata_q;
    assign bus.m_tvalid = tvalid_q;
    assign bus.m_rw     = rw_q;
    assign bus.busy     = busy;
    assign bus.overrun  = overrun_q;
endmodule
